// File: rtl/pw_pkg.sv
// Shared state encoding, digit constants and default timing for the pushbutton
// code sequencer.
package pw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_CHECK,
    ST_UNLOCK,
    ST_FAIL,
    ST_LOCKOUT
  } state_e;

  localparam logic [1:0] DIG_A = 2'd0;
  localparam logic [1:0] DIG_B = 2'd1;
  localparam logic [1:0] DIG_C = 2'd2;
  localparam logic [1:0] DIG_D = 2'd3;

  localparam int unsigned TICK_DIV_DEF      = 40_000_000;
  localparam logic [7:0]  CODE_DEF          = 8'b11_10_01_00;
  localparam int unsigned TIMEOUT_TICKS_DEF = 4;
  localparam int unsigned LOCK_TICKS_DEF    = 8;

  // Caller guarantees exactly one bit of btn is set.
  function automatic logic [1:0] btn_digit(input logic [3:0] btn);
    logic [1:0] dig;
    dig = DIG_A;
    if (btn[1]) dig = DIG_B;
    if (btn[2]) dig = DIG_C;
    if (btn[3]) dig = DIG_D;
    return dig;
  endfunction

  // First n LEDs lit; bit 0 is leda.
  function automatic logic [3:0] led_bar(input logic [2:0] n);
    return 4'((5'd1 << n) - 5'd1);
  endfunction

endpackage

// File: rtl/pw_sequencer_if.sv
// Button inputs and status outputs of the code sequencer.
interface pw_sequencer_if;
  logic a, b, c, d, turnoff;
  logic leda, ledb, ledc, ledd;
  logic unlocked, alarm;

  modport master (
    output a, b, c, d, turnoff,
    input  leda, ledb, ledc, ledd, unlocked, alarm
  );

  modport slave (
    input  a, b, c, d, turnoff,
    output leda, ledb, ledc, ledd, unlocked, alarm
  );
endinterface

// File: rtl/pw_tick_gen.sv
// Timing tick divider: one-cycle pulse every TICK_DIV cycles, re-phased by restart.
module pw_tick_gen
  import pw_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
  input  logic clkin,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned   CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || tick) cnt_d = '0;
  end

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pw_sequencer.sv
// Four-digit pushbutton code lock: synchronised button edges drive an entry,
// check, fail-blink and lockout sequence with tick-based timeouts.
module pw_sequencer
  import pw_pkg::*;
#(
  parameter int unsigned TICK_DIV      = TICK_DIV_DEF,
  parameter logic [7:0]  CODE          = CODE_DEF,
  parameter int unsigned TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
  parameter int unsigned LOCK_TICKS    = LOCK_TICKS_DEF
) (
  input  logic          clkin,
  input  logic          reset,
  pw_sequencer_if.slave io
);

  localparam int unsigned    TMAX_A  = (TIMEOUT_TICKS > LOCK_TICKS) ? TIMEOUT_TICKS : LOCK_TICKS;
  localparam int unsigned    TMAX    = (TMAX_A > 2) ? TMAX_A : 2;
  localparam int unsigned    TCW     = $clog2(TMAX);
  localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT_TICKS - 1);
  localparam logic [TCW-1:0] LK_LAST = TCW'(LOCK_TICKS - 1);
  localparam logic [TCW-1:0] FL_LAST = TCW'(1);

  logic [4:0]     sync1_q, sync1_d, sync2_q, sync2_d;
  logic [4:0]     hist_q, hist_d, press_q, press_d;
  state_e         state_q, state_d;
  logic [7:0]     entry_q, entry_d;
  logic [1:0]     ndig_q, ndig_d;
  logic [1:0]     fails_q, fails_d;
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic [3:0]     leds_q, leds_d;
  logic           unlocked_q, unlocked_d;
  logic           alarm_q, alarm_d;
  logic           tick, restart, accept;
  logic           off_press, valid;
  logic [1:0]     digit;

  // Edge detection is registered so a press reaches the FSM three edges
  // after the input is first sampled high.
  always_comb begin
    sync1_d = {io.turnoff, io.d, io.c, io.b, io.a};
    sync2_d = sync1_q;
    hist_d  = sync2_q;
    press_d = sync2_q & ~hist_q;
  end

  assign off_press = press_q[4];
  assign valid     = $onehot(press_q[3:0]);
  assign digit     = btn_digit(press_q[3:0]);

  pw_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clkin   (clkin),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    ndig_d     = ndig_q;
    fails_d    = fails_q;
    tcnt_d     = tcnt_q;
    leds_d     = leds_q;
    unlocked_d = unlocked_q;
    alarm_d    = alarm_q;
    accept     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!off_press && valid) begin
          entry_d = {6'b0, digit};
          ndig_d  = 2'd1;
          leds_d  = led_bar(3'd1);
          accept  = 1'b1;
          state_d = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (off_press) begin
          state_d = ST_IDLE;
        end else if (valid) begin
          entry_d[{ndig_q, 1'b0} +: 2] = digit;
          ndig_d = ndig_q + 2'd1;
          leds_d = led_bar({1'b0, ndig_q} + 3'd1);
          accept = 1'b1;
          if (ndig_q == 2'd3) state_d = ST_CHECK;
        end else if (tick) begin
          if (tcnt_q == TO_LAST) state_d = ST_IDLE;
          else                   tcnt_d  = tcnt_q + TCW'(1);
        end
      end
      ST_CHECK: begin
        if (off_press) begin
          state_d = ST_IDLE;
        end else if (entry_q == CODE) begin
          state_d    = ST_UNLOCK;
          unlocked_d = 1'b1;
          fails_d    = '0;
          leds_d     = '1;
        end else begin
          fails_d = fails_q + 2'd1;
          if (fails_q == 2'd2) begin
            state_d = ST_LOCKOUT;
            alarm_d = 1'b1;
            leds_d  = '0;
          end else begin
            state_d = ST_FAIL;
            leds_d  = '1;
          end
        end
      end
      ST_UNLOCK: begin
        if (off_press) state_d = ST_IDLE;
      end
      ST_FAIL: begin
        if (off_press) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (tcnt_q == FL_LAST) begin
            state_d = ST_IDLE;
          end else begin
            leds_d = ~leds_q;
            tcnt_d = tcnt_q + TCW'(1);
          end
        end
      end
      ST_LOCKOUT: begin
        if (tick) begin
          if (tcnt_q == LK_LAST) begin
            state_d = ST_IDLE;
            fails_d = '0;
          end else begin
            tcnt_d = tcnt_q + TCW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Every path back to IDLE discards the entry and clears the outputs.
    if (state_d == ST_IDLE) begin
      entry_d    = '0;
      ndig_d     = '0;
      leds_d     = '0;
      unlocked_d = 1'b0;
      alarm_d    = 1'b0;
    end

    restart = accept || (state_d != state_q);
    if (restart) tcnt_d = '0;
  end

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      hist_q     <= '0;
      press_q    <= '0;
      state_q    <= ST_IDLE;
      entry_q    <= '0;
      ndig_q     <= '0;
      fails_q    <= '0;
      tcnt_q     <= '0;
      leds_q     <= '0;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      hist_q     <= hist_d;
      press_q    <= press_d;
      state_q    <= state_d;
      entry_q    <= entry_d;
      ndig_q     <= ndig_d;
      fails_q    <= fails_d;
      tcnt_q     <= tcnt_d;
      leds_q     <= leds_d;
      unlocked_q <= unlocked_d;
      alarm_q    <= alarm_d;
    end
  end

  assign io.leda     = leds_q[0];
  assign io.ledb     = leds_q[1];
  assign io.ledc     = leds_q[2];
  assign io.ledd     = leds_q[3];
  assign io.unlocked = unlocked_q;
  assign io.alarm    = alarm_q;

endmodule

// File: doc/pw_sequencer.md
PW_SEQUENCER -- requirements
Module: pw_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 40_000_000; clkin cycles per timing tick.
REQ-002 Parameter CODE, default 8'b11_10_01_00; four 2-bit digits, digit0 in [1:0], entered first.
REQ-003 Parameter TIMEOUT_TICKS, default 4; idle ticks allowed between digits.
REQ-004 Parameter LOCK_TICKS, default 8; lockout duration in ticks.
REQ-005 clkin  input  1  system clock; single clock domain, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 a, b, c, d  input  1 each  asynchronous push buttons; digit encoding a=0, b=1, c=2, d=3.
REQ-008 turnoff  input  1  asynchronous abort/clear request.
REQ-009 leda, ledb, ledc, ledd  output  1 each  registered progress/status LEDs.
REQ-010 unlocked  output  1  registered; high while code accepted.
REQ-011 alarm  output  1  registered; high during lockout.

Function
REQ-012 a, b, c, d and turnoff SHALL each pass a 2-flop synchronizer; a press is a 0->1 edge on the synchronized signal.
REQ-013 An input high at clkin edge N SHALL produce its output effect at edge N+3 (exactly 3-cycle latency).
REQ-014 Press edges on more than one button in the same cycle SHALL be ignored, with no digit and no state change.
REQ-015 States: IDLE, ENTRY, CHECK, UNLOCK, FAIL, LOCKOUT.
REQ-016 IDLE: LEDs off; the first valid press stores digit0 -> ENTRY, leda=1.
REQ-017 ENTRY: k digits stored SHALL light the first k LEDs in order a..d; the 4th digit -> CHECK.
REQ-018 CHECK SHALL last exactly one cycle and compare the 8-bit entry with CODE.
REQ-019 On a match: -> UNLOCK, all LEDs=1, unlocked=1, fail counter cleared; remain until turnoff.
REQ-020 On a mismatch: 2-bit fail counter increments; count<3 -> FAIL, count==3 -> LOCKOUT.
REQ-021 FAIL: all LEDs SHALL toggle together on each tick, starting on; after 2 ticks -> IDLE with LEDs off.
REQ-022 LOCKOUT: alarm=1, LEDs off, buttons and turnoff ignored; after LOCK_TICKS ticks -> IDLE, alarm=0, fail counter=0.
REQ-023 ENTRY timeout: TIMEOUT_TICKS ticks with no valid press -> IDLE; entry discarded, fail counter unchanged.
REQ-024 Tick: counter 0..TICK_DIV-1 emits a 1-cycle pulse at TICK_DIV-1; restarts at 0 on every state change and every accepted digit.
REQ-025 turnoff edge in ENTRY, CHECK, FAIL or UNLOCK -> IDLE next cycle, entry cleared, unlocked=0; fail counter unchanged.
REQ-026 If a turnoff edge and a button edge occur in the same cycle, turnoff SHALL win and the button is ignored.
REQ-027 Presses in CHECK, FAIL and UNLOCK SHALL be ignored.

Reset
REQ-028 reset low SHALL asynchronously force IDLE, all LEDs=0, unlocked=0, alarm=0, fail counter=0, tick counter=0, entry=0, synchronizers=0.
REQ-029 Reset asserted mid-operation, including LOCKOUT, SHALL abandon the operation without pending effects after release.

Structure
REQ-030 Package pw_pkg SHALL hold the state enum, the digit encoding constants and default parameter values.
REQ-031 Sub-module pw_tick_gen SHALL implement the REQ-024 divider (inputs clkin, reset, restart; output tick).
REQ-032 Synchronizers, edge detect, FSM and entry register SHALL stay in pw_sequencer.

Verification (TICK_DIV=4, TIMEOUT_TICKS=4, LOCK_TICKS=8)
REQ-033 Press a, b, c, d in order -> LEDs 1000, 1100, 1110, 1111; then CHECK -> unlocked=1; turnoff -> all outputs 0.
REQ-034 Press a, a, a, a three times -> two FAIL blink sequences, then alarm=1 for 32 cycles; buttons ignored throughout; then IDLE.
REQ-035 Press a, b, then no input for 16 cycles -> IDLE, LEDs 0000, fail counter still 0.
REQ-036 Press a and c in the same cycle -> no LED change; turnoff coincident with a press in ENTRY -> IDLE.
REQ-037 Assert reset during LOCKOUT -> alarm=0 immediately; then a correct code unlocks on the first attempt.
REQ-038 Latency check: press a held from edge N -> leda=1 exactly at edge N+3.
